// File: rtl/instr_mem_server_pkg.sv
// ============================================================================
// Module : roxxon_pkg
// Brief  : Shared types and constants for the instruction-store server.
//          Optional build macro: IMEM_PARITY_EN (adds a stored parity bit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package roxxon_pkg;

  // Server operating mode.
  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } imem_state_t;

  // Source currently presented on INSTRDATA.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_HALT = 2'd2
  } imem_src_t;

  localparam logic [31:0] HALT_OP_DEFAULT = 32'h0000_0000;

`ifdef IMEM_PARITY_EN
  localparam int IMEM_W = 33;   // data word plus even-parity bit
`else
  localparam int IMEM_W = 32;
`endif

  // Address width for a store of n words; never below 1 bit.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_server_if.sv
// ============================================================================
// Module : instr_mem_server_if
// Brief  : Load port, fetch port and status bundle of the instruction store.
//          master = host/fetch side, slave = instr_mem_server.
//          Optional build macro: IMEM_PARITY_EN (adds PAR_ERR).
// Ports  : LD_VALID/LD_READY/LD_DATA/LD_LAST  program load handshake
//          RELOAD                             discard program, back to LOAD
//          PC -> INSTRDATA/INSTR_VALID/OOR    fetch with 1-cycle latency
//          LOADED_LEN                         words in current program
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_mem_server_if #(
  parameter int AW = 9
);
  logic          LD_VALID;
  logic          LD_READY;
  logic [31:0]   LD_DATA;
  logic          LD_LAST;
  logic          RELOAD;
  logic [AW-1:0] PC;
  logic [31:0]   INSTRDATA;
  logic          INSTR_VALID;
  logic [AW:0]   LOADED_LEN;
  logic          OOR;
`ifdef IMEM_PARITY_EN
  logic          PAR_ERR;

  modport master (
    output LD_VALID, LD_DATA, LD_LAST, RELOAD, PC,
    input  LD_READY, INSTRDATA, INSTR_VALID, LOADED_LEN, OOR, PAR_ERR
  );
  modport slave (
    input  LD_VALID, LD_DATA, LD_LAST, RELOAD, PC,
    output LD_READY, INSTRDATA, INSTR_VALID, LOADED_LEN, OOR, PAR_ERR
  );
`else
  modport master (
    output LD_VALID, LD_DATA, LD_LAST, RELOAD, PC,
    input  LD_READY, INSTRDATA, INSTR_VALID, LOADED_LEN, OOR
  );
  modport slave (
    input  LD_VALID, LD_DATA, LD_LAST, RELOAD, PC,
    output LD_READY, INSTRDATA, INSTR_VALID, LOADED_LEN, OOR
  );
`endif
endinterface

`default_nettype wire

// File: rtl/instr_mem_server_array.sv
// ============================================================================
// Module : imem_array
// Brief  : Single-write, single-registered-read storage. No reset on the
//          contents or the read register so it maps onto block RAM.
// Ports  : CLK                        clock
//          we_i/waddr_i/wdata_i       write port
//          re_i/raddr_i/rdata_o       registered read port (holds when !re_i)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_array #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int W     = 32
) (
  input  wire logic          CLK,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire logic [W-1:0]  wdata_i,
  input  wire logic          re_i,
  input  wire logic [AW-1:0] raddr_i,
  output logic      [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/instr_mem_server.sv
// ============================================================================
// Module : instr_mem_server
// Brief  : Instruction store for the fetch stage. LOAD accepts program words
//          over a valid/ready port; SERVE returns mem[PC] one cycle later,
//          or HALT_OP when PC lies beyond the loaded program.
//          Optional build macro: IMEM_PARITY_EN (even parity per word,
//          PAR_ERR pulse and HALT_OP substitution on a corrupted read).
// Ports  : CLK   clock, rising edge
//          RSTN  asynchronous reset, active high
//          bus   instr_mem_server_if.slave (load, fetch and status signals)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_server
  import roxxon_pkg::*;
#(
  parameter int          REGN    = 512,
  parameter logic [31:0] HALT_OP = HALT_OP_DEFAULT,
  localparam int         AW      = calc_aw(REGN)
) (
  input wire logic         CLK,
  input wire logic         RSTN,
  instr_mem_server_if.slave bus
);

  imem_state_t state_q, state_d;
  // The write pointer and the program length are always equal after a
  // transfer or a clear, so one AW+1 bit register serves as both.
  logic [AW:0] wp_q, wp_d;

  logic        ld_ready, wr_en, rd_en, last_xfer;
  logic        valid_q, oor_q;
  imem_src_t   src_q;
  logic [AW:0] pc_ext;
  logic        in_range;
  logic [IMEM_W-1:0] wdata, rdata;

  assign pc_ext   = {1'b0, bus.PC};
  assign in_range = pc_ext < wp_q;
  assign last_xfer = bus.LD_LAST || (wp_q == (AW+1)'(REGN - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) state_q <= LOAD;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (!bus.RELOAD && wr_en && last_xfer) state_d = SERVE;
      SERVE:   if (bus.RELOAD)                        state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // RELOAD wins over a load word presented on the same edge: the word is
  // taken off the port but discarded, so no store write happens.
  always_comb begin
    ld_ready = (state_q == LOAD) && !RSTN;
    wr_en    = ld_ready && bus.LD_VALID && !bus.RELOAD;
    rd_en    = (state_q == SERVE) && !bus.RELOAD;
  end

  // ---------------- write pointer / program length ----------------
  always_comb begin
    wp_d = wp_q;
    if (bus.RELOAD)  wp_d = '0;
    else if (wr_en)  wp_d = wp_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) wp_q <= '0;
    else      wp_q <= wp_d;
  end

  // ---------------- read-side status ----------------
  // src_q records what the last SERVE read produced. Together with the
  // store's read register (which holds while not enabled) it keeps
  // INSTRDATA stable outside SERVE and zero after reset.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      valid_q <= 1'b0;
      oor_q   <= 1'b0;
      src_q   <= SRC_ZERO;
    end else begin
      valid_q <= rd_en;
      if (rd_en) begin
        oor_q <= !in_range;
        src_q <= in_range ? SRC_MEM : SRC_HALT;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic fresh_q, par_bad;

  assign wdata   = {^bus.LD_DATA, bus.LD_DATA};
  assign par_bad = ^rdata;   // even parity over data+parity must be 0

  // PAR_ERR pulses only for the cycle following the faulty read.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) fresh_q <= 1'b0;
    else      fresh_q <= rd_en;
  end

  assign bus.PAR_ERR = fresh_q && (src_q == SRC_MEM) && par_bad;
`else
  logic par_bad;
  assign wdata   = bus.LD_DATA;
  assign par_bad = 1'b0;
`endif

  always_comb begin
    case (src_q)
      SRC_MEM:  bus.INSTRDATA = par_bad ? HALT_OP : rdata[31:0];
      SRC_HALT: bus.INSTRDATA = HALT_OP;
      default:  bus.INSTRDATA = 32'h0;
    endcase
  end

  assign bus.LD_READY    = ld_ready;
  assign bus.INSTR_VALID = valid_q;
  assign bus.OOR         = oor_q;
  assign bus.LOADED_LEN  = wp_q;

  imem_array #(
    .DEPTH (REGN),
    .AW    (AW),
    .W     (IMEM_W)
  ) u_array (
    .CLK     (CLK),
    .we_i    (wr_en),
    .waddr_i (wp_q[AW-1:0]),
    .wdata_i (wdata),
    .re_i    (rd_en),
    .raddr_i (bus.PC),
    .rdata_o (rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_server.sv
// ============================================================================
// Module : tb_instr_mem_server
// Brief  : Directed bench for instr_mem_server (REGN=8) with a fetch
//          scoreboard. Parity checks compile only with IMEM_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_server;
  localparam int          REGN = 8;
  localparam int          AW   = 3;
  localparam logic [31:0] HALT = 32'hDEAD_0013;
  localparam logic [31:0] BAD  = 32'hBAAD_F00D;

  logic CLK  = 1'b0;
  logic RSTN = 1'b1;
  always #5 CLK = ~CLK;

  instr_mem_server_if #(.AW(AW)) bus ();

  instr_mem_server #(.REGN(REGN), .HALT_OP(HALT)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [REGN];
  int          model_len = 0;

  typedef struct {
    logic [31:0] data;
    logic        oor;
    logic        perr;
  } exp_t;
  exp_t sbq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = d;
    bus.LD_LAST  = last;
    model_mem[model_len] = d;
    model_len++;
    tick();
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
  endtask

  // Drive PC, predict the word for the next edge, compare after it.
  task automatic serve(input logic [AW-1:0] pc, input logic corrupt);
    exp_t e;
    exp_t got;
    bus.PC = pc;
    e.oor  = !(int'(pc) < model_len);
    e.data = (e.oor || corrupt) ? HALT : model_mem[pc];
    e.perr = corrupt;
    sbq.push_back(e);
    tick();
    got = sbq.pop_front();
    chk("serve_data",  bus.INSTRDATA,   got.data);
    chk("serve_oor",   bus.OOR,         got.oor);
    chk("serve_valid", bus.INSTR_VALID, 1'b1);
`ifdef IMEM_PARITY_EN
    chk("serve_parerr", bus.PAR_ERR, got.perr);
`endif
  endtask

  initial begin
    logic [31:0] m0;
    bus.LD_VALID = 1'b0;
    bus.LD_DATA  = '0;
    bus.LD_LAST  = 1'b0;
    bus.RELOAD   = 1'b0;
    bus.PC       = '0;

    // Reset state
    tick(); tick();
    chk("rst_instrdata", bus.INSTRDATA,   32'h0);
    chk("rst_valid",     bus.INSTR_VALID, 1'b0);
    chk("rst_oor",       bus.OOR,         1'b0);
    chk("rst_ld_ready",  bus.LD_READY,    1'b0);
    chk("rst_len",       bus.LOADED_LEN,  4'd0);
    RSTN = 1'b0;
    #1;
    chk("load_ready", bus.LD_READY, 1'b1);

    // Load 4 words, LAST on the 4th
    load_word(32'h1111_0000, 1'b0);
    load_word(32'h1111_0001, 1'b0);
    load_word(32'h1111_0002, 1'b0);
    chk("len3",        bus.LOADED_LEN, 4'd3);
    chk("ready_mid",   bus.LD_READY,   1'b1);
    load_word(32'h1111_0003, 1'b1);
    chk("len4",        bus.LOADED_LEN,  4'd4);
    chk("ready_serve", bus.LD_READY,    1'b0);
    chk("valid_entry", bus.INSTR_VALID, 1'b0);

    // Serve in range, beyond, then back in range
    for (int i = 0; i < 4; i++) serve(AW'(i), 1'b0);
    serve(3'd4, 1'b0);
    serve(3'd2, 1'b0);

    // RELOAD with a load word offered: back to LOAD, outputs held
    bus.RELOAD   = 1'b1;
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = BAD;
    tick();
    bus.RELOAD   = 1'b0;
    bus.LD_VALID = 1'b0;
    model_len    = 0;
    chk("reload_valid", bus.INSTR_VALID, 1'b0);
    chk("reload_len",   bus.LOADED_LEN,  4'd0);
    chk("reload_ready", bus.LD_READY,    1'b1);
    chk("reload_hold",  bus.INSTRDATA,   32'h1111_0002);

    // LD_VALID toggling 1,0,1: two transfers only
    load_word(32'hA000_0000, 1'b0);
    tick();
    load_word(32'hA000_0001, 1'b0);
    chk("toggle_len",   bus.LOADED_LEN, 4'd2);
    chk("toggle_ready", bus.LD_READY,   1'b1);

    // Fill to REGN without LAST: store full forces SERVE
    for (int i = 2; i < REGN; i++) load_word(32'hA000_0000 + 32'(i), 1'b0);
    chk("full_len",   bus.LOADED_LEN, 4'd8);
    chk("full_ready", bus.LD_READY,   1'b0);
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = BAD;
    serve(3'd0, 1'b0);
    bus.LD_VALID = 1'b0;
    serve(3'd7, 1'b0);
    chk("full_len_kept", bus.LOADED_LEN, 4'd8);

    // RELOAD at full pointer with a word offered: store untouched
    bus.RELOAD   = 1'b1;
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = BAD;
    tick();
    bus.RELOAD   = 1'b0;
    bus.LD_VALID = 1'b0;
    model_len    = 0;
    chk("reload2_len",   bus.LOADED_LEN,  4'd0);
    chk("reload2_valid", bus.INSTR_VALID, 1'b0);
    m0 = dut.u_array.mem_q[0][31:0];
    chk("reload2_mem0", m0, 32'hA000_0000);

    // Async reset between edges after 3 loads
    load_word(32'hB000_0000, 1'b0);
    load_word(32'hB000_0001, 1'b0);
    load_word(32'hB000_0002, 1'b0);
    @(negedge CLK);
    #2;
    RSTN = 1'b1;
    #1;
    chk("async_instrdata", bus.INSTRDATA,  32'h0);
    chk("async_len",       bus.LOADED_LEN, 4'd0);
    chk("async_ready",     bus.LD_READY,   1'b0);
    chk("async_valid",     bus.INSTR_VALID, 1'b0);
    tick();
    RSTN      = 1'b0;
    model_len = 0;

    // Fresh 2-word program
    load_word(32'hC000_0000, 1'b0);
    load_word(32'hC000_0001, 1'b1);
    chk("c_len", bus.LOADED_LEN, 4'd2);
    serve(3'd0, 1'b0);
    serve(3'd1, 1'b0);
    serve(3'd2, 1'b0);

`ifdef IMEM_PARITY_EN
    dut.u_array.mem_q[1][5] = ~dut.u_array.mem_q[1][5];
    serve(3'd1, 1'b1);
    serve(3'd0, 1'b0);
`endif

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
